// File: rtl/bus_pkg.sv
// bus_pkg: shared types and helpers for the shared-bus arbiter.
//   bus_state_t : transaction FSM states (IDLE/GRANT/ACTIVE/FINISH)
//   fault_t     : fault reason codes reported on fault_reason
//   ARB_FIXED / ARB_RR : arbitration mode selectors
//   lsb_index   : index of the lowest set bit of a vector of up to 32 bits
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_FINISH = 2'd3
    } bus_state_t;

    typedef enum logic [2:0] {
        FAULT_NONE          = 3'd0,
        FAULT_NO_SLAVE      = 3'd1,
        FAULT_CHANGED_SLAVE = 3'd2,
        FAULT_WITHDRAWN     = 3'd3,
        FAULT_TIMEOUT       = 3'd4
    } fault_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Width of the vector lsb_index works on; callers zero-extend into it,
    // which bounds NUM_SLAVES to 32.
    localparam int LSB_W = 32;

    // Lowest set bit wins; returns 0 for an all-zero vector.
    function automatic logic [4:0] lsb_index(input logic [LSB_W-1:0] v);
        logic [4:0] idx;
        idx = 5'd0;
        for (int i = LSB_W - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: winner select for NUM_MASTERS requesters.
//   ARB_MODE = ARB_FIXED : lowest requesting index wins.
//   ARB_MODE = ARB_RR    : search starts one above rr_ptr and wraps;
//                          rr_ptr takes the winner whenever advance is high.
// Ports:
//   clk, reset : clock, synchronous active-high reset (rr_ptr -> NUM_MASTERS-1)
//   req        : per-master request (any op)
//   advance    : a grant is being issued this cycle
//   any_req    : at least one request present
//   winner     : index of the selected master (valid when any_req)
module bus_rr_arbiter import bus_pkg::*; #(
    parameter int NUM_MASTERS = 4,
    parameter int ARB_MODE    = ARB_FIXED
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic                           advance,
    output logic                           any_req,
    output logic [$clog2(NUM_MASTERS)-1:0] winner
);

    localparam int MW = $clog2(NUM_MASTERS);

    logic [MW-1:0] rr_ptr;
    int            cand;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (ARB_MODE == ARB_RR) cand = (int'(rr_ptr) + i) % NUM_MASTERS;
            else                    cand = i - 1;
            if (!any_req && req[MW'(cand)]) begin
                any_req = 1'b1;
                winner  = MW'(cand);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= MW'(NUM_MASTERS - 1);
        end else if (advance && (ARB_MODE == ARB_RR)) begin
            rr_ptr <= winner;
        end
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: shared-bus controller, NUM_MASTERS masters onto one bus of
// NUM_SLAVES ack-decoded slaves. Address/write data are latched at grant,
// one timer bounds the whole transaction, and faults record reason, address
// and master.
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   master_addr/wdata            : per-master address / write data (packed slices)
//   master_rreq/wreq             : per-master read / write requests
//   master_acc                   : one-hot grant
//   master_rdata, master_busy    : read data from locked slave, transfer pending
//   slave_addr/wdata             : latched address / write data
//   slave_rreq/wreq              : read / write strobes
//   slave_rdata/ack/busy         : per-slave read data, address claim, busy
//   fault, fault_reason,
//   fault_addr, fault_master     : one-cycle pulse plus held fault record
module bus_arbiter_rr import bus_pkg::*; #(
    parameter int NUM_MASTERS = 4,
    parameter int NUM_SLAVES  = 8,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int ARB_MODE    = ARB_FIXED,
    parameter int TIMEOUT     = 10000000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_MASTERS*ADDR_W-1:0]  master_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]  master_wdata,
    input  logic [NUM_MASTERS-1:0]         master_rreq,
    input  logic [NUM_MASTERS-1:0]         master_wreq,
    output logic [NUM_MASTERS-1:0]         master_acc,
    output logic [DATA_W-1:0]              master_rdata,
    output logic                           master_busy,
    output logic [ADDR_W-1:0]              slave_addr,
    output logic [DATA_W-1:0]              slave_wdata,
    output logic                           slave_rreq,
    output logic                           slave_wreq,
    input  logic [NUM_SLAVES*DATA_W-1:0]   slave_rdata,
    input  logic [NUM_SLAVES-1:0]          slave_ack,
    input  logic [NUM_SLAVES-1:0]          slave_busy,
    output logic                           fault,
    output logic [2:0]                     fault_reason,
    output logic [ADDR_W-1:0]              fault_addr,
    output logic [$clog2(NUM_MASTERS)-1:0] fault_master
);

    localparam int MW = $clog2(NUM_MASTERS);
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TW = $clog2(TIMEOUT);

    bus_state_t       state;
    logic [MW-1:0]    win_idx;
    logic             win_is_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [SW-1:0]    slave_sel;
    logic             sel_locked;
    logic [TW-1:0]    timer;

    logic             arb_any;
    logic [MW-1:0]    arb_winner;
    logic             arb_advance;
    logic [LSB_W-1:0] ack_ext;
    logic [SW-1:0]    ack_low;
    logic             ack_any;
    logic             op_req;
    logic             timed_out;
    logic             raise;
    fault_t           raise_code;

    assign arb_advance = (state == ST_IDLE) && arb_any;

    bus_rr_arbiter #(
        .NUM_MASTERS (NUM_MASTERS),
        .ARB_MODE    (ARB_MODE)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (master_rreq | master_wreq),
        .advance (arb_advance),
        .any_req (arb_any),
        .winner  (arb_winner)
    );

    always_comb begin
        ack_ext                 = '0;
        ack_ext[NUM_SLAVES-1:0] = slave_ack;
    end

    assign ack_low   = SW'(lsb_index(ack_ext));
    assign ack_any   = |slave_ack;
    // The op latched at grant is the one that must stay requested.
    assign op_req    = win_is_write ? master_wreq[win_idx] : master_rreq[win_idx];
    assign timed_out = (timer == TW'(TIMEOUT - 1));

    // Fault detection; takes precedence over any completion in the same cycle.
    always_comb begin
        raise      = 1'b0;
        raise_code = FAULT_NONE;
        case (state)
            ST_GRANT: begin
                if (!op_req) begin
                    raise      = 1'b1;
                    raise_code = FAULT_WITHDRAWN;
                end
            end
            ST_ACTIVE: begin
                if (!ack_any) begin
                    raise      = 1'b1;
                    raise_code = FAULT_NO_SLAVE;
                end else if (sel_locked && (ack_low != slave_sel)) begin
                    raise      = 1'b1;
                    raise_code = FAULT_CHANGED_SLAVE;
                end else if (timed_out) begin
                    raise      = 1'b1;
                    raise_code = FAULT_TIMEOUT;
                end
            end
            ST_FINISH: begin
                if (timed_out) begin
                    raise      = 1'b1;
                    raise_code = FAULT_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (state)
            ST_GRANT:  master_busy = 1'b1;
            ST_ACTIVE: master_busy = !sel_locked || slave_busy[slave_sel];
            ST_FINISH: master_busy = slave_busy[slave_sel];
            default:   master_busy = 1'b0;
        endcase
    end

    assign master_rdata = sel_locked ? slave_rdata[slave_sel*DATA_W +: DATA_W] : '0;
    assign slave_addr   = addr_q;
    assign slave_wdata  = wdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            win_idx      <= '0;
            win_is_write <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            slave_sel    <= '0;
            sel_locked   <= 1'b0;
            timer        <= '0;
            master_acc   <= '0;
            slave_rreq   <= 1'b0;
            slave_wreq   <= 1'b0;
            fault        <= 1'b0;
            fault_reason <= 3'd0;
            fault_addr   <= '0;
            fault_master <= '0;
        end else begin
            fault <= 1'b0;
            if (raise) begin
                fault        <= 1'b1;
                fault_reason <= raise_code;
                fault_addr   <= addr_q;
                fault_master <= win_idx;
                master_acc   <= '0;
                slave_rreq   <= 1'b0;
                slave_wreq   <= 1'b0;
                sel_locked   <= 1'b0;
                state        <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arb_any) begin
                            win_idx      <= arb_winner;
                            // Read wins when a master asserts both requests.
                            win_is_write <= !master_rreq[arb_winner];
                            addr_q       <= master_addr[arb_winner*ADDR_W +: ADDR_W];
                            wdata_q      <= master_wdata[arb_winner*DATA_W +: DATA_W];
                            master_acc   <= NUM_MASTERS'(1) << arb_winner;
                            state        <= ST_GRANT;
                        end
                    end
                    ST_GRANT: begin
                        slave_rreq <= !win_is_write;
                        slave_wreq <= win_is_write;
                        timer      <= '0;
                        state      <= ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        timer      <= timer + TW'(1);
                        slave_sel  <= ack_low;
                        sel_locked <= 1'b1;
                        if (!op_req) begin
                            slave_rreq <= 1'b0;
                            slave_wreq <= 1'b0;
                            master_acc <= '0;
                            if (slave_busy[ack_low]) begin
                                state <= ST_FINISH;
                            end else begin
                                sel_locked <= 1'b0;
                                state      <= ST_IDLE;
                            end
                        end
                    end
                    ST_FINISH: begin
                        timer <= timer + TW'(1);
                        if (!slave_busy[slave_sel]) begin
                            sel_locked <= 1'b0;
                            state      <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a fixed-priority instance and a
// round-robin instance share one set of stimulus; each test checks the
// instance it targets, with a reset between tests.
module tb_bus_arbiter_rr;

    localparam int NM = 4;
    localparam int NS = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NM*AW-1:0] m_addr;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]    m_rreq, m_wreq;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0]    s_ack, s_busy;

    logic [NM-1:0] f_acc, r_acc;
    logic [DW-1:0] f_rdata, r_rdata;
    logic          f_mbusy, r_mbusy;
    logic [AW-1:0] f_saddr, r_saddr;
    logic [DW-1:0] f_swdata, r_swdata;
    logic          f_srreq, r_srreq, f_swreq, r_swreq;
    logic          f_fault, r_fault;
    logic [2:0]    f_reason, r_reason;
    logic [AW-1:0] f_faddr, r_faddr;
    logic [1:0]    f_fmaster, r_fmaster;

    int nvec = 0;
    int nerr = 0;

    logic [3:0] rr_exp [4] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};

    bus_arbiter_rr #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
        .ARB_MODE(0), .TIMEOUT(TO)
    ) u_fix (
        .clk(clk), .reset(reset),
        .master_addr(m_addr), .master_wdata(m_wdata),
        .master_rreq(m_rreq), .master_wreq(m_wreq),
        .master_acc(f_acc), .master_rdata(f_rdata), .master_busy(f_mbusy),
        .slave_addr(f_saddr), .slave_wdata(f_swdata),
        .slave_rreq(f_srreq), .slave_wreq(f_swreq),
        .slave_rdata(s_rdata), .slave_ack(s_ack), .slave_busy(s_busy),
        .fault(f_fault), .fault_reason(f_reason),
        .fault_addr(f_faddr), .fault_master(f_fmaster)
    );

    bus_arbiter_rr #(
        .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
        .ARB_MODE(1), .TIMEOUT(TO)
    ) u_rr (
        .clk(clk), .reset(reset),
        .master_addr(m_addr), .master_wdata(m_wdata),
        .master_rreq(m_rreq), .master_wreq(m_wreq),
        .master_acc(r_acc), .master_rdata(r_rdata), .master_busy(r_mbusy),
        .slave_addr(r_saddr), .slave_wdata(r_swdata),
        .slave_rreq(r_srreq), .slave_wreq(r_swreq),
        .slave_rdata(s_rdata), .slave_ack(s_ack), .slave_busy(s_busy),
        .fault(r_fault), .fault_reason(r_reason),
        .fault_addr(r_faddr), .fault_master(r_fmaster)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        m_addr  = '0;
        m_wdata = '0;
        m_rreq  = '0;
        m_wreq  = '0;
        s_rdata = '0;
        s_ack   = '0;
        s_busy  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_acc",     64'(f_acc),     64'h0);
        check_eq("rst_rr_acc",  64'(r_acc),     64'h0);
        check_eq("rst_srreq",   64'(f_srreq),   64'h0);
        check_eq("rst_swreq",   64'(f_swreq),   64'h0);
        check_eq("rst_mbusy",   64'(f_mbusy),   64'h0);
        check_eq("rst_fault",   64'(f_fault),   64'h0);
        check_eq("rst_reason",  64'(f_reason),  64'h0);
        check_eq("rst_saddr",   64'(f_saddr),   64'h0);
        check_eq("rst_rdata",   64'(f_rdata),   64'h0);

        // Fixed-priority read: master 2 -> slave 3
        m_rreq                = 4'b0100;
        m_addr[2*AW +: AW]    = 32'h0000_1000;
        s_ack                 = 8'h08;
        s_busy                = 8'h08;
        s_rdata[3*DW +: DW]   = 32'hCAFE_F00D;
        step();
        check_eq("rd_acc",      64'(f_acc),     64'h4);
        check_eq("rd_no_strobe",64'(f_srreq),   64'h0);
        check_eq("rd_busy_gnt", 64'(f_mbusy),   64'h1);
        step();
        check_eq("rd_strobe",   64'(f_srreq),   64'h1);
        check_eq("rd_saddr",    64'(f_saddr),   64'h1000);
        check_eq("rd_unlocked", 64'(f_rdata),   64'h0);
        check_eq("rd_fault0",   64'(f_fault),   64'h0);
        step();
        check_eq("rd_rdata",    64'(f_rdata),   64'hCAFE_F00D);
        check_eq("rd_busy_act", 64'(f_mbusy),   64'h1);
        check_eq("rd_fault1",   64'(f_fault),   64'h0);
        m_rreq = 4'b0000;
        step();
        check_eq("rd_acc_drop", 64'(f_acc),     64'h0);
        check_eq("rd_strb_drop",64'(f_srreq),   64'h0);
        check_eq("rd_busy_fin", 64'(f_mbusy),   64'h1);
        check_eq("rd_fault2",   64'(f_fault),   64'h0);
        step();
        s_busy = 8'h00;
        #1;
        check_eq("rd_busy_done",64'(f_mbusy),   64'h0);
        step();
        check_eq("rd_idle_busy",64'(f_mbusy),   64'h0);
        check_eq("rd_idle_data",64'(f_rdata),   64'h0);
        check_eq("rd_fault3",   64'(f_fault),   64'h0);

        // Round-robin fairness: masters 0 and 1 both hold wreq
        do_reset();
        m_wreq = 4'b0011;
        s_ack  = 8'h01;
        for (int t = 0; t < 4; t++) begin
            step();
            check_eq($sformatf("rr_grant%0d", t), 64'(r_acc), 64'(rr_exp[t]));
            if (t == 0) check_eq("fix_contend", 64'(f_acc), 64'h1);
            step();
            check_eq($sformatf("rr_wstrobe%0d", t), 64'(r_swreq), 64'h1);
            step();
            step();
            m_wreq = m_wreq & ~rr_exp[t];
            step();
            check_eq($sformatf("rr_release%0d", t), 64'(r_acc), 64'h0);
            m_wreq = 4'b0011;
        end

        // Address latching: master 1 write, inputs change after grant
        do_reset();
        m_wreq              = 4'b0010;
        m_addr[1*AW +: AW]  = 32'h20;
        m_wdata[1*DW +: DW] = 32'h55;
        s_ack               = 8'h01;
        step();
        check_eq("lat_acc",     64'(f_acc),     64'h2);
        m_addr[1*AW +: AW]  = 32'hFF;
        m_wdata[1*DW +: DW] = 32'hAA;
        #1;
        check_eq("lat_saddr0",  64'(f_saddr),   64'h20);
        check_eq("lat_wdata0",  64'(f_swdata),  64'h55);
        step();
        check_eq("lat_wstrobe", 64'(f_swreq),   64'h1);
        check_eq("lat_saddr1",  64'(f_saddr),   64'h20);
        step();
        check_eq("lat_saddr2",  64'(f_saddr),   64'h20);
        m_wreq = 4'b0000;
        step();
        check_eq("lat_done_acc",64'(f_acc),     64'h0);
        check_eq("lat_done_wr", 64'(f_swreq),   64'h0);

        // Withdrawn request: master 3 pulses rreq for one cycle
        do_reset();
        m_rreq             = 4'b1000;
        m_addr[3*AW +: AW] = 32'h300;
        step();
        check_eq("wd_acc",      64'(f_acc),     64'h8);
        m_rreq = 4'b0000;
        step();
        check_eq("wd_fault",    64'(f_fault),   64'h1);
        check_eq("wd_reason",   64'(f_reason),  64'h3);
        check_eq("wd_master",   64'(f_fmaster), 64'h3);
        check_eq("wd_faddr",    64'(f_faddr),   64'h300);
        check_eq("wd_acc0",     64'(f_acc),     64'h0);
        check_eq("wd_nostrobe", 64'(f_srreq),   64'h0);
        step();
        check_eq("wd_pulse1",   64'(f_fault),   64'h0);
        check_eq("wd_hold",     64'(f_reason),  64'h3);

        // No slave acks
        do_reset();
        m_rreq             = 4'b0001;
        m_addr[0*AW +: AW] = 32'h40;
        step();
        step();
        check_eq("ns_strobe",   64'(f_srreq),   64'h1);
        step();
        check_eq("ns_fault",    64'(f_fault),   64'h1);
        check_eq("ns_reason",   64'(f_reason),  64'h1);
        check_eq("ns_faddr",    64'(f_faddr),   64'h40);
        check_eq("ns_strb0",    64'(f_srreq),   64'h0);
        m_rreq = 4'b0000;

        // Ack moves from slave 3 to slave 5
        do_reset();
        m_rreq              = 4'b0010;
        m_addr[1*AW +: AW]  = 32'h1234;
        s_ack               = 8'h08;
        s_busy              = 8'hFF;
        s_rdata[3*DW +: DW] = 32'h3333_3333;
        step();
        step();
        step();
        check_eq("cs_rdata",    64'(f_rdata),   64'h3333_3333);
        s_ack = 8'h20;
        step();
        check_eq("cs_fault",    64'(f_fault),   64'h1);
        check_eq("cs_reason",   64'(f_reason),  64'h2);
        check_eq("cs_faddr",    64'(f_faddr),   64'h1234);
        check_eq("cs_master",   64'(f_fmaster), 64'h1);
        check_eq("cs_strb0",    64'(f_srreq),   64'h0);
        check_eq("cs_unlock",   64'(f_rdata),   64'h0);
        m_rreq = 4'b0000;

        // Timeout: slave busy forever, TIMEOUT = 16
        do_reset();
        m_rreq             = 4'b0100;
        m_addr[2*AW +: AW] = 32'h600;
        s_ack              = 8'h01;
        s_busy             = 8'hFF;
        step();
        step();
        check_eq("to_active",   64'(f_srreq),   64'h1);
        for (int k = 1; k < 16; k++) begin
            step();
            check_eq($sformatf("to_early%0d", k), 64'(f_fault), 64'h0);
        end
        step();
        check_eq("to_fault",    64'(f_fault),   64'h1);
        check_eq("to_reason",   64'(f_reason),  64'h4);
        check_eq("to_strb0",    64'(f_srreq),   64'h0);
        check_eq("to_acc0",     64'(f_acc),     64'h0);
        check_eq("to_faddr",    64'(f_faddr),   64'h600);

        // Reset during ACTIVE clears everything without a fault
        step();
        step();
        check_eq("mr_active",   64'(f_srreq),   64'h1);
        reset = 1'b1;
        step();
        check_eq("mr_acc",      64'(f_acc),     64'h0);
        check_eq("mr_srreq",    64'(f_srreq),   64'h0);
        check_eq("mr_fault",    64'(f_fault),   64'h0);
        check_eq("mr_reason",   64'(f_reason),  64'h0);
        check_eq("mr_faddr",    64'(f_faddr),   64'h0);
        check_eq("mr_mbusy",    64'(f_mbusy),   64'h0);
        reset  = 1'b0;
        m_rreq = 4'b0000;
        step();
        check_eq("mr_nofault",  64'(f_fault),   64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
